// File: rtl/mpmc10_wr_strip_gen.sv
// Write-side strip sequencer for mpmc10: streams num_strips+1 data beats into the MIG
// write-data channel and issues one write command per strip, never ahead of its data.
module mpmc10_wr_strip_gen #(
  parameter int unsigned DW     = 128,
  parameter int unsigned SSHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       addr_base,
  input  logic [5:0]        num_strips,
  input  logic [DW-1:0]     din,
  input  logic [DW/8-1:0]   din_mask,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [31:0]       app_addr,
  input  logic              app_rdy,
  output logic              app_wdf_wren,
  output logic [DW-1:0]     app_wdf_data,
  output logic [DW/8-1:0]   app_wdf_mask,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MW  = DW / 8;
  localparam int unsigned CW  = 7;
  localparam int unsigned AHW = 32 - SSHIFT;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] dat_cnt, cmd_cnt, dat_acc;
  logic [CW-1:0] dat_cnt_nxt, cmd_cnt_nxt, dat_acc_nxt;
  logic [5:0]    last;
  logic          start_acc, din_hs, wdf_hs, cmd_hs, app_en_nxt;

  assign app_cmd     = 3'b000;
  assign app_wdf_end = app_wdf_wren;
  assign din_hs      = din_valid && din_ready;
  assign wdf_hs      = app_wdf_wren && app_wdf_rdy;
  assign cmd_hs      = app_en && app_rdy;

  // Next-state, counter updates and the data-channel ready
  always_comb begin
    state_nxt   = state;
    start_acc   = 1'b0;
    din_ready   = 1'b0;
    dat_cnt_nxt = dat_cnt + CW'(din_hs);
    cmd_cnt_nxt = cmd_cnt + CW'(cmd_hs);
    dat_acc_nxt = dat_acc + CW'(wdf_hs);
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        din_ready = (dat_cnt <= {1'b0, last}) && (!app_wdf_wren || app_wdf_rdy);
        if ((cmd_cnt_nxt > {1'b0, last}) && (dat_cnt_nxt > {1'b0, last}))
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (start_acc) begin
      dat_cnt_nxt = '0;
      cmd_cnt_nxt = '0;
      dat_acc_nxt = '0;
    end
    // A command is only offered for strips whose data the MIG has already taken
    app_en_nxt = (state_nxt == RUN) && (cmd_cnt_nxt < dat_acc_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      dat_cnt      <= '0;
      cmd_cnt      <= '0;
      dat_acc      <= '0;
      last         <= '0;
      app_en       <= 1'b0;
      app_addr     <= 32'h1FFF_FFFF;
      app_wdf_wren <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state   <= state_nxt;
      dat_cnt <= dat_cnt_nxt;
      cmd_cnt <= cmd_cnt_nxt;
      dat_acc <= dat_acc_nxt;
      app_en  <= app_en_nxt;
      busy    <= (state_nxt == RUN);
      done    <= (state_nxt == DONE);
      if (start_acc) begin
        app_addr <= addr_base;
        last     <= num_strips;
      end else if (cmd_hs) begin
        app_addr <= {app_addr[31:SSHIFT] + AHW'(1), app_addr[SSHIFT-1:0]};
      end
      // One-entry output register: reload on intake, otherwise drop once accepted
      if (din_hs) begin
        app_wdf_data <= din;
        app_wdf_mask <= MW'(din_mask);
        app_wdf_wren <= 1'b1;
      end else if (wdf_hs) begin
        app_wdf_wren <= 1'b0;
      end
    end
  end

endmodule
